irq_rr_arbiter: RTL and testbench

Round-robin interrupt arbiter with per-source edge/level capture and a service handshake. It sits between the peripheral request lines and the core's interrupt entry logic. It latches requests and masks them with `mie_i`. It selects one source fairly, presents its cause, holds it in service until the interrupt return, and then acknowledges the serviced peripheral. It is the fair-arbitration alternative to the fixed-priority daisy chain, with the same cause and return conventions.

---
 rtl/irq_rr_arbiter_if.sv | 21 ++
 rtl/irq_rr_arbiter.sv | 66 ++++++
 tb/tb_irq_rr_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/irq_rr_arbiter_if.sv
// irq_rr_arbiter_if: request, mask and service handshake bundle between peripherals/core and the arbiter
interface irq_rr_arbiter_if #(parameter int N = 16);
    logic [N-1:0] irq_src_i;
    logic [N-1:0] edge_mode_i;
    logic [N-1:0] mie_i;
    logic         ready_i;
    logic         irq_ret_i;
    logic         irq_o;
    logic [31:0]  irq_cause_o;
    logic [N-1:0] irq_ret_o;
    logic [N-1:0] pending_o;
    logic         busy_o;
    modport slave (
        input  irq_src_i, edge_mode_i, mie_i, ready_i, irq_ret_i,
        output irq_o, irq_cause_o, irq_ret_o, pending_o, busy_o
    );
    modport master (
        output irq_src_i, edge_mode_i, mie_i, ready_i, irq_ret_i,
        input  irq_o, irq_cause_o, irq_ret_o, pending_o, busy_o
    );
endinterface

// File: rtl/irq_rr_arbiter.sv
// irq_rr_arbiter: round-robin interrupt arbiter with edge/level capture and grant/return handshake
module irq_rr_arbiter #(
    parameter int          N          = 16,
    parameter logic [31:0] CAUSE_BASE = 32'h8000_0010
) (
    input logic                clk_i,
    input logic                rst_ni,
    irq_rr_arbiter_if.slave    bus
);
    localparam int PW = $clog2(N);
    typedef enum logic {IDLE, SERVICE} state_t;
    state_t          state_q;
    logic [N-1:0]    src_q, pend_q, pend_d, rise, elig, sel_oh;
    logic [PW-1:0]   ptr_q, idx_q, sel;
    logic            found, grant;
    assign rise  = bus.irq_src_i & ~src_q & bus.edge_mode_i;
    assign elig  = (pend_q | (bus.irq_src_i & ~bus.edge_mode_i)) & bus.mie_i;
    assign grant = (state_q == IDLE) & bus.ready_i & found;
    assign sel_oh = N'(1) << sel;
    // First eligible source at or above the pointer, wrapping past N-1
    always_comb begin
        int j;
        found = 1'b0;
        sel   = '0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            j = (j >= N) ? j - N : j;
            if (!found && elig[j]) begin
                found = 1'b1;
                sel   = PW'(j);
            end
        end
    end
    // A rise on the source being granted re-arms its pending bit
    assign pend_d = (pend_q & ~(grant ? sel_oh : '0)) | rise;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            idx_q           <= '0;
            src_q           <= '0;
            pend_q          <= '0;
            bus.irq_o       <= 1'b0;
            bus.irq_cause_o <= '0;
            bus.irq_ret_o   <= '0;
        end else begin
            src_q         <= bus.irq_src_i;
            pend_q        <= pend_d;
            bus.irq_o     <= 1'b0;
            bus.irq_ret_o <= '0;
            if (state_q == IDLE && grant) begin
                bus.irq_o       <= 1'b1;
                bus.irq_cause_o <= CAUSE_BASE + 32'(sel);
                idx_q           <= sel;
                state_q         <= SERVICE;
            end else if (state_q == SERVICE && bus.irq_ret_i) begin
                bus.irq_ret_o <= N'(1) << idx_q;
                ptr_q         <= (idx_q == PW'(N - 1)) ? '0 : idx_q + 1'b1;
                state_q       <= IDLE;
            end
        end
    end
    assign bus.pending_o = pend_q;
    assign bus.busy_o    = (state_q == SERVICE);
endmodule

// File: tb/tb_irq_rr_arbiter.sv
// tb_irq_rr_arbiter: directed scenario checks of the round-robin interrupt arbiter
module tb_irq_rr_arbiter;
    logic clk;
    logic rst_ni;
    int   n_cmp;
    int   n_fail;
    irq_rr_arbiter_if #(.N(16)) bus ();
    irq_rr_arbiter #(.N(16), .CAUSE_BASE(32'h8000_0010)) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus.slave)
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.irq_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask
    task automatic clear_inputs();
        bus.irq_src_i   = '0;
        bus.edge_mode_i = '0;
        bus.mie_i       = 16'hFFFF;
        bus.ready_i     = 1'b1;
        bus.irq_ret_i   = 1'b0;
    endtask
    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        tick();
        rst_ni = 1'b1;
    endtask
    task automatic test_reset();
        rst_ni = 1'b0;
        clear_inputs();
        bus.irq_src_i = 16'h0008;
        tick();
        tick();
        n_cmp++; if (bus.irq_o !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b exp 0", bus.irq_o); end
        n_cmp++; if (bus.irq_cause_o !== 32'h0) begin n_fail++; $display("FAIL rst_cause: got %h exp 0", bus.irq_cause_o); end
        n_cmp++; if ({bus.irq_ret_o, bus.pending_o, bus.busy_o} !== 33'h0) begin n_fail++; $display("FAIL rst_misc: got %h exp 0", {bus.irq_ret_o, bus.pending_o, bus.busy_o}); end
        bus.irq_src_i = '0;
        rst_ni = 1'b1;
        tick();
        n_cmp++; if (bus.irq_o !== 1'b0) begin n_fail++; $display("FAIL rst_idle_irq: got %b exp 0", bus.irq_o); end
    endtask
    task automatic test_level_grant();
        bus.irq_src_i = 16'h0008;
        tick();
        n_cmp++; if (bus.irq_o !== 1'b1) begin n_fail++; $display("FAIL lvl_irq: got %b exp 1", bus.irq_o); end
        n_cmp++; if (bus.irq_cause_o !== 32'h8000_0013) begin n_fail++; $display("FAIL lvl_cause: got %h exp 80000013", bus.irq_cause_o); end
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL lvl_busy: got %b exp 1", bus.busy_o); end
        bus.irq_src_i = '0;
        tick();
        n_cmp++; if (bus.irq_o !== 1'b0) begin n_fail++; $display("FAIL lvl_pulse: got %b exp 0", bus.irq_o); end
        bus.irq_ret_i = 1'b1;
        tick();
        bus.irq_ret_i = 1'b0;
        n_cmp++; if (bus.irq_ret_o !== 16'h0008) begin n_fail++; $display("FAIL lvl_ret: got %h exp 0008", bus.irq_ret_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL lvl_idle: got %b exp 0", bus.busy_o); end
        tick();
        n_cmp++; if (bus.irq_ret_o !== 16'h0) begin n_fail++; $display("FAIL lvl_ret_pulse: got %h exp 0", bus.irq_ret_o); end
    endtask
    task automatic test_round_robin();
        logic [31:0] exp_cause [4] = '{32'h8000_0011, 32'h8000_0015, 32'h8000_0011, 32'h8000_0015};
        logic [15:0] exp_ret   [4] = '{16'h0002, 16'h0020, 16'h0002, 16'h0020};
        bit ok;
        do_reset();
        bus.irq_src_i = 16'h0022;
        for (int g = 0; g < 4; g++) begin
            wait_grant(ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL rr_grant%0d: got no grant exp grant", g); end
            n_cmp++; if (bus.irq_cause_o !== exp_cause[g]) begin n_fail++; $display("FAIL rr_cause%0d: got %h exp %h", g, bus.irq_cause_o, exp_cause[g]); end
            tick();
            tick();
            bus.irq_ret_i = 1'b1;
            tick();
            bus.irq_ret_i = 1'b0;
            n_cmp++; if (bus.irq_ret_o !== exp_ret[g]) begin n_fail++; $display("FAIL rr_ret%0d: got %h exp %h", g, bus.irq_ret_o, exp_ret[g]); end
        end
        bus.irq_src_i = '0;
    endtask
    task automatic test_edge_merge();
        bit ok;
        int cnt;
        bus.edge_mode_i = 16'h0004;
        bus.irq_src_i   = 16'h0001;
        wait_grant(ok);
        n_cmp++; if (!ok || bus.irq_cause_o !== 32'h8000_0010) begin n_fail++; $display("FAIL edge_first: got ok=%b cause %h exp 80000010", ok, bus.irq_cause_o); end
        bus.irq_src_i = 16'h0004;
        tick();
        n_cmp++; if (bus.pending_o !== 16'h0004) begin n_fail++; $display("FAIL edge_pend1: got %h exp 0004", bus.pending_o); end
        bus.irq_src_i = '0;
        tick();
        bus.irq_src_i = 16'h0004;
        tick();
        bus.irq_src_i = '0;
        tick();
        n_cmp++; if (bus.pending_o !== 16'h0004) begin n_fail++; $display("FAIL edge_merge: got %h exp 0004", bus.pending_o); end
        bus.irq_ret_i = 1'b1;
        tick();
        bus.irq_ret_i = 1'b0;
        n_cmp++; if (bus.irq_ret_o !== 16'h0001) begin n_fail++; $display("FAIL edge_ret0: got %h exp 0001", bus.irq_ret_o); end
        tick();
        n_cmp++; if (bus.irq_o !== 1'b1 || bus.irq_cause_o !== 32'h8000_0012) begin n_fail++; $display("FAIL edge_grant2: got irq %b cause %h exp 1 80000012", bus.irq_o, bus.irq_cause_o); end
        n_cmp++; if (bus.pending_o !== 16'h0) begin n_fail++; $display("FAIL edge_clr: got %h exp 0", bus.pending_o); end
        bus.irq_ret_i = 1'b1;
        tick();
        bus.irq_ret_i = 1'b0;
        n_cmp++; if (bus.irq_ret_o !== 16'h0004) begin n_fail++; $display("FAIL edge_ret2: got %h exp 0004", bus.irq_ret_o); end
        cnt = 0;
        repeat (4) begin tick(); cnt += int'(bus.irq_o); end
        n_cmp++; if (cnt !== 0) begin n_fail++; $display("FAIL edge_once: got %0d extra grants exp 0", cnt); end
    endtask
    task automatic test_mask_set_wins();
        int cnt;
        bus.edge_mode_i = 16'h0008;
        bus.mie_i       = 16'hFFF7;
        bus.irq_src_i   = 16'h0008;
        cnt = 0;
        tick();
        cnt += int'(bus.irq_o);
        bus.irq_src_i = '0;
        repeat (3) begin tick(); cnt += int'(bus.irq_o); end
        n_cmp++; if (cnt !== 0) begin n_fail++; $display("FAIL mask_nogrant: got %0d grants exp 0", cnt); end
        n_cmp++; if (bus.pending_o !== 16'h0008) begin n_fail++; $display("FAIL mask_keep: got %h exp 0008", bus.pending_o); end
        bus.mie_i     = 16'hFFFF;
        bus.irq_src_i = 16'h0008;
        tick();
        n_cmp++; if (bus.irq_o !== 1'b1 || bus.irq_cause_o !== 32'h8000_0013) begin n_fail++; $display("FAIL mask_unmask: got irq %b cause %h exp 1 80000013", bus.irq_o, bus.irq_cause_o); end
        n_cmp++; if (bus.pending_o !== 16'h0008) begin n_fail++; $display("FAIL set_wins: got %h exp 0008", bus.pending_o); end
        bus.irq_src_i = '0;
        tick();
        bus.irq_ret_i = 1'b1;
        tick();
        bus.irq_ret_i = 1'b0;
        n_cmp++; if (bus.irq_ret_o !== 16'h0008) begin n_fail++; $display("FAIL mask_ret: got %h exp 0008", bus.irq_ret_o); end
        tick();
        n_cmp++; if (bus.irq_o !== 1'b1 || bus.pending_o !== 16'h0) begin n_fail++; $display("FAIL set_wins_regrant: got irq %b pend %h exp 1 0000", bus.irq_o, bus.pending_o); end
        bus.irq_ret_i = 1'b1;
        tick();
        bus.irq_ret_i = 1'b0;
    endtask
    task automatic test_wrap_ignore();
        bit ok;
        do_reset();
        bus.irq_src_i = 16'h4000;
        wait_grant(ok);
        n_cmp++; if (!ok || bus.irq_cause_o !== 32'h8000_001E) begin n_fail++; $display("FAIL wrap_g14: got ok=%b cause %h exp 8000001e", ok, bus.irq_cause_o); end
        bus.irq_src_i = 16'h4001;
        bus.irq_ret_i = 1'b1;
        tick();
        bus.irq_ret_i = 1'b0;
        n_cmp++; if (bus.irq_ret_o !== 16'h4000) begin n_fail++; $display("FAIL wrap_ret14: got %h exp 4000", bus.irq_ret_o); end
        tick();
        n_cmp++; if (bus.irq_o !== 1'b1 || bus.irq_cause_o !== 32'h8000_0010) begin n_fail++; $display("FAIL wrap_g0: got irq %b cause %h exp 1 80000010", bus.irq_o, bus.irq_cause_o); end
        bus.irq_src_i = '0;
        bus.irq_ret_i = 1'b1;
        tick();
        bus.irq_ret_i = 1'b0;
        n_cmp++; if (bus.irq_ret_o !== 16'h0001) begin n_fail++; $display("FAIL wrap_ret0: got %h exp 0001", bus.irq_ret_o); end
        tick();
        bus.irq_ret_i = 1'b1;
        tick();
        bus.irq_ret_i = 1'b0;
        n_cmp++; if (bus.irq_ret_o !== 16'h0 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL ignore_ret: got ret %h busy %b exp 0000 0", bus.irq_ret_o, bus.busy_o); end
        tick();
        n_cmp++; if (bus.irq_ret_o !== 16'h0) begin n_fail++; $display("FAIL ignore_ret2: got %h exp 0", bus.irq_ret_o); end
    endtask
    task automatic test_reset_mid_service();
        bit ok;
        do_reset();
        bus.irq_src_i = 16'h0400;
        wait_grant(ok);
        n_cmp++; if (!ok || bus.irq_cause_o !== 32'h8000_001A) begin n_fail++; $display("FAIL mrst_g10: got ok=%b cause %h exp 8000001a", ok, bus.irq_cause_o); end
        bus.irq_src_i = '0;
        bus.irq_ret_i = 1'b1;
        tick();
        bus.irq_ret_i   = 1'b0;
        bus.edge_mode_i = 16'h0050;
        bus.irq_src_i   = 16'h0001;
        tick();
        n_cmp++; if (bus.irq_o !== 1'b1 || bus.irq_cause_o !== 32'h8000_0010) begin n_fail++; $display("FAIL mrst_g0: got irq %b cause %h exp 1 80000010", bus.irq_o, bus.irq_cause_o); end
        bus.irq_src_i = 16'h0050;
        tick();
        bus.irq_src_i = '0;
        n_cmp++; if (bus.pending_o !== 16'h0050 || bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL mrst_pend: got pend %h busy %b exp 0050 1", bus.pending_o, bus.busy_o); end
        #1 rst_ni = 1'b0;
        #1;
        n_cmp++; if (bus.pending_o !== 16'h0 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL mrst_async: got pend %h busy %b exp 0000 0", bus.pending_o, bus.busy_o); end
        n_cmp++; if (bus.irq_cause_o !== 32'h0 || bus.irq_o !== 1'b0 || bus.irq_ret_o !== 16'h0) begin n_fail++; $display("FAIL mrst_outs: got cause %h irq %b ret %h exp 0", bus.irq_cause_o, bus.irq_o, bus.irq_ret_o); end
        tick();
        rst_ni = 1'b1;
        bus.irq_ret_i = 1'b1;
        tick();
        bus.irq_ret_i = 1'b0;
        n_cmp++; if (bus.irq_ret_o !== 16'h0) begin n_fail++; $display("FAIL mrst_noret: got %h exp 0", bus.irq_ret_o); end
        bus.edge_mode_i = '0;
        bus.irq_src_i   = 16'h1008;
        wait_grant(ok);
        n_cmp++; if (!ok || bus.irq_cause_o !== 32'h8000_0013) begin n_fail++; $display("FAIL mrst_ptr0: got ok=%b cause %h exp 80000013", ok, bus.irq_cause_o); end
        bus.irq_src_i = '0;
        bus.irq_ret_i = 1'b1;
        tick();
        bus.irq_ret_i = 1'b0;
    endtask
    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_level_grant();
        test_round_robin();
        test_edge_merge();
        test_mask_set_wins();
        test_wrap_ignore();
        test_reset_mid_service();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
